scheduler_request_issuer: RTL and testbench
===========================================

// Module: scheduler_request_issuer
// PURPOSE
//   Initiator side of the Scheduler request handshake (enabled/finished, hasSchedule/schedulePid,
//   hasDeschedule/deschedulePid). Buffers wake-up (schedule) requests from channel logic in a FIFO,
//   takes deschedule requests from core 0 and core 1, and issues them to the Scheduler one transaction
//   at a time. When a deschedule and a queued wake-up are both pending, it merges them into one transaction.
// PARAMETERS
//   addrBits   `ADDRESS_BITS   width of a process id
//   queueDepth 8               wake-up FIFO entries; power of two, >= 2
// PORTS
//   clk                 in   1         system clock
//   reset               in   1         synchronous, active-high
//   wakeValid           in   1         a wake-up request is offered this cycle
//   wakePid             in   addrBits  pid to schedule
//   wakeReady           out  1         FIFO can accept (count < queueDepth)
//   core0DescheduleReq  in   1         level; held by core 0 until its ack
//   core0DeschedulePid  in   addrBits  pid core 0 is yielding
//   core0DescheduleAck  out  1         1-cycle pulse: core 0 request completed
//   core1DescheduleReq  in   1         as core 0
//   core1DeschedulePid  in   addrBits
//   core1DescheduleAck  out  1
//   schedEnabled        out  1         to Scheduler.enabled
//   schedFinished       in   1         from Scheduler.finished
//   hasSchedule         out  1         to Scheduler
//   schedulePid         out  addrBits
//   hasDeschedule       out  1         to Scheduler
//   deschedulePid       out  addrBits
//   queueCount          out  log2(queueDepth)+1  wake-up entries held
//   overflowError       out  1         sticky: wakeValid while !wakeReady
// BEHAVIOUR
//   Reset: all outputs 0, FIFO empty, state IDLE; wakeReady is 1 after reset. A reset mid-transaction
//     drops schedEnabled on the next edge and discards the latched request; no ack is issued.
//   FIFO: push on wakeValid && wakeReady; pop only at transaction completion. A push and a pop in the
//     same cycle leave queueCount unchanged. The pointers wrap modulo queueDepth. Ordering is FIFO.
//   The decision is made in IDLE from registered state. Deschedule priority is core0, then core1.
//     - If a deschedule is pending: hasDeschedule=1 with that core's pid. hasSchedule=1 with the FIFO
//       head if the FIFO is non-empty, else 0.
//     - Else, if the FIFO is non-empty: hasSchedule=1 with the head; hasDeschedule=0.
//     - Else: remain in IDLE.
//   FSM:
//     IDLE  -> ISSUE  when there is work. On this edge, latch the has*/pid outputs and set schedEnabled=1.
//       This gives 1-cycle latency from a registered request to enabled.
//     ISSUE -> DRAIN  on schedFinished=1. On this edge: schedEnabled=0, pop the FIFO if hasSchedule,
//       and pulse the chosen core's ack if hasDeschedule.
//       The has*/pid outputs stay stable for the whole of ISSUE.
//     DRAIN -> IDLE   once schedFinished=0. No new issue is made while finished is still high.
//   A core's request is not re-sampled during ISSUE/DRAIN. The core deasserts its req on the cycle after its ack.
//   A wake-up arriving during ISSUE is queued for the next transaction. It is never merged into the
//     in-flight transaction.
//   overflowError: set on wakeValid && !wakeReady; the offered pid is dropped; cleared only by reset.
// TESTING
//   1. Reset, then wakeValid pid=1 for one cycle -> one transaction: hasSchedule=1, schedulePid=1,
//      hasDeschedule=0. schedEnabled drops on the edge after finished. queueCount goes 1 -> 0.
//   2. Push pids 2, 3 back-to-back -> two separate transactions in order 2 then 3. The second
//      schedEnabled rises only after finished has fallen.
//   3. core0DescheduleReq pid=1 with FIFO empty -> hasDeschedule=1, deschedulePid=1, hasSchedule=0.
//      core0DescheduleAck pulses exactly once.
//   4. core0 req pid=2 and core1 req pid=3 plus queued pid=4 -> first transaction merges deschedule 2
//      with schedule 4 (core0 ack). Second is deschedule 3 only (core1 ack).
//   5. Push queueDepth+1 pids with no finished -> wakeReady=0 at depth and overflowError=1.
//      The first queueDepth pids are then issued in order.
//   6. Assert reset during ISSUE -> schedEnabled=0 and queueCount=0 next cycle, no ack pulse.
//      overflowError is cleared.

Source files
------------

// File: rtl/scheduler_request_issuer.sv
// scheduler_request_issuer
// Initiator side of the Scheduler request handshake. Wake-up pids from channel
// logic are buffered in a FIFO. Deschedule requests come from core 0 and core 1,
// with core 0 taking priority. Requests go to the Scheduler one transaction at a
// time, and a pending deschedule is merged with the FIFO head when both exist.
// All handshake outputs come straight from flops.

`ifndef ADDRESS_BITS
`define ADDRESS_BITS 8
`endif

module scheduler_request_issuer #(
   parameter int addrBits   = `ADDRESS_BITS,
   parameter int queueDepth = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        wakeValid,
   input  logic [addrBits-1:0]         wakePid,
   output logic                        wakeReady,
   input  logic                        core0DescheduleReq,
   input  logic [addrBits-1:0]         core0DeschedulePid,
   output logic                        core0DescheduleAck,
   input  logic                        core1DescheduleReq,
   input  logic [addrBits-1:0]         core1DeschedulePid,
   output logic                        core1DescheduleAck,
   output logic                        schedEnabled,
   input  logic                        schedFinished,
   output logic                        hasSchedule,
   output logic [addrBits-1:0]         schedulePid,
   output logic                        hasDeschedule,
   output logic [addrBits-1:0]         deschedulePid,
   output logic [$clog2(queueDepth):0] queueCount,
   output logic                        overflowError
);

   localparam int PTR_W = $clog2(queueDepth);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(queueDepth);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [addrBits-1:0] PID_ZERO = {addrBits{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t state_q, state_d;

   // FIFO storage and bookkeeping
   logic [addrBits-1:0] mem_q [queueDepth];
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                wake_ready_q, wake_ready_d;
   logic                overflow_q, overflow_d;
   logic                push_s;
   logic                pop_s;

   // Transaction registers driving the Scheduler and the cores
   logic                enabled_q, enabled_d;
   logic                has_sched_q, has_sched_d;
   logic [addrBits-1:0] sched_pid_q, sched_pid_d;
   logic                has_desched_q, has_desched_d;
   logic [addrBits-1:0] desched_pid_q, desched_pid_d;
   logic                core_sel_q, core_sel_d;   // 0: core 0 owns the deschedule, 1: core 1
   logic                ack0_q, ack0_d;
   logic                ack1_q, ack1_d;

   // Decision inputs, all taken from registered state or held core levels
   logic                fifo_nonempty_s;
   logic                desched_pending_s;
   logic                work_s;
   logic [addrBits-1:0] head_pid_s;

   assign fifo_nonempty_s   = (count_q != CNT_ZERO);
   assign desched_pending_s = core0DescheduleReq | core1DescheduleReq;
   assign work_s            = desched_pending_s | fifo_nonempty_s;
   assign head_pid_s        = mem_q[rd_ptr_q];

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: issue when there is work, wait for finished to rise then fall
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (work_s) begin
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (schedFinished) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_DRAIN: begin
            if (!schedFinished) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output logic: latch the request on issue, pop/ack and clear it on completion
   always_comb begin
      enabled_d     = enabled_q;
      has_sched_d   = has_sched_q;
      sched_pid_d   = sched_pid_q;
      has_desched_d = has_desched_q;
      desched_pid_d = desched_pid_q;
      core_sel_d    = core_sel_q;
      ack0_d        = 1'b0;
      ack1_d        = 1'b0;
      pop_s         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (work_s) begin
               enabled_d = 1'b1;
               if (core0DescheduleReq) begin
                  has_desched_d = 1'b1;
                  desched_pid_d = core0DeschedulePid;
                  core_sel_d    = 1'b0;
               end else if (core1DescheduleReq) begin
                  has_desched_d = 1'b1;
                  desched_pid_d = core1DeschedulePid;
                  core_sel_d    = 1'b1;
               end else begin
                  has_desched_d = 1'b0;
                  desched_pid_d = PID_ZERO;
                  core_sel_d    = 1'b0;
               end
               has_sched_d = fifo_nonempty_s;
               sched_pid_d = fifo_nonempty_s ? head_pid_s : PID_ZERO;
            end else begin
               enabled_d = 1'b0;
            end
         end
         ST_ISSUE: begin
            if (schedFinished) begin
               enabled_d     = 1'b0;
               pop_s         = has_sched_q;
               ack0_d        = has_desched_q & ~core_sel_q;
               ack1_d        = has_desched_q & core_sel_q;
               has_sched_d   = 1'b0;
               sched_pid_d   = PID_ZERO;
               has_desched_d = 1'b0;
               desched_pid_d = PID_ZERO;
            end else begin
               enabled_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            enabled_d = 1'b0;
         end
         default: begin
            enabled_d = 1'b0;
         end
      endcase
   end

   // Transaction output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         enabled_q     <= 1'b0;
         has_sched_q   <= 1'b0;
         sched_pid_q   <= PID_ZERO;
         has_desched_q <= 1'b0;
         desched_pid_q <= PID_ZERO;
         core_sel_q    <= 1'b0;
         ack0_q        <= 1'b0;
         ack1_q        <= 1'b0;
      end else begin
         enabled_q     <= enabled_d;
         has_sched_q   <= has_sched_d;
         sched_pid_q   <= sched_pid_d;
         has_desched_q <= has_desched_d;
         desched_pid_q <= desched_pid_d;
         core_sel_q    <= core_sel_d;
         ack0_q        <= ack0_d;
         ack1_q        <= ack1_d;
      end
   end

   // FIFO pointer, occupancy, ready and sticky overflow next-state
   always_comb begin
      push_s     = wakeValid & wake_ready_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (wakeValid & ~wake_ready_q);
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      if (push_s && !pop_s) begin
         count_d = count_q + CNT_ONE;
      end else if (pop_s && !push_s) begin
         count_d = count_q - CNT_ONE;
      end else begin
         count_d = count_q;
      end
      wake_ready_d = (count_d < DEPTH_C);
   end

   // FIFO control registers
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q     <= {PTR_W{1'b0}};
         wr_ptr_q     <= {PTR_W{1'b0}};
         count_q      <= CNT_ZERO;
         wake_ready_q <= 1'b1;
         overflow_q   <= 1'b0;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         wake_ready_q <= wake_ready_d;
         overflow_q   <= overflow_d;
      end
   end

   // FIFO storage write; contents need no reset because occupancy gates every read
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= wakePid;
      end
   end

   assign wakeReady          = wake_ready_q;
   assign overflowError      = overflow_q;
   assign queueCount         = count_q;
   assign schedEnabled       = enabled_q;
   assign hasSchedule        = has_sched_q;
   assign schedulePid        = sched_pid_q;
   assign hasDeschedule      = has_desched_q;
   assign deschedulePid      = desched_pid_q;
   assign core0DescheduleAck = ack0_q;
   assign core1DescheduleAck = ack1_q;

endmodule

// File: tb/tb_scheduler_request_issuer.sv
// Directed, table-driven bench for scheduler_request_issuer (addrBits=8, queueDepth=8).
// Each table row gives the inputs for one cycle and the outputs expected just after
// the following clock edge. FIFO overflow and reset during ISSUE are hand-written sequences.

module tb_scheduler_request_issuer;

   logic       clk;
   logic       reset;
   logic       wakeValid;
   logic [7:0] wakePid;
   logic       wakeReady;
   logic       core0DescheduleReq;
   logic [7:0] core0DeschedulePid;
   logic       core0DescheduleAck;
   logic       core1DescheduleReq;
   logic [7:0] core1DeschedulePid;
   logic       core1DescheduleAck;
   logic       schedEnabled;
   logic       schedFinished;
   logic       hasSchedule;
   logic [7:0] schedulePid;
   logic       hasDeschedule;
   logic [7:0] deschedulePid;
   logic [3:0] queueCount;
   logic       overflowError;

   int n_checks;
   int n_errors;

   scheduler_request_issuer #(.addrBits(8), .queueDepth(8)) dut (
      .clk                (clk),
      .reset              (reset),
      .wakeValid          (wakeValid),
      .wakePid            (wakePid),
      .wakeReady          (wakeReady),
      .core0DescheduleReq (core0DescheduleReq),
      .core0DeschedulePid (core0DeschedulePid),
      .core0DescheduleAck (core0DescheduleAck),
      .core1DescheduleReq (core1DescheduleReq),
      .core1DeschedulePid (core1DeschedulePid),
      .core1DescheduleAck (core1DescheduleAck),
      .schedEnabled       (schedEnabled),
      .schedFinished      (schedFinished),
      .hasSchedule        (hasSchedule),
      .schedulePid        (schedulePid),
      .hasDeschedule      (hasDeschedule),
      .deschedulePid      (deschedulePid),
      .queueCount         (queueCount),
      .overflowError      (overflowError)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       wv;
      logic [7:0] wp;
      logic       c0;
      logic [7:0] c0p;
      logic       c1;
      logic [7:0] c1p;
      logic       fin;
      logic       rdy;
      logic       a0;
      logic       a1;
      logic       en;
      logic       hs;
      logic [7:0] sp;
      logic       hd;
      logic [7:0] dp;
      logic [3:0] cnt;
      logic       ovf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic rst, input logic wv, input logic [7:0] wp,
      input logic c0, input logic [7:0] c0p, input logic c1, input logic [7:0] c1p,
      input logic fin,
      input logic rdy, input logic a0, input logic a1, input logic en,
      input logic hs, input logic [7:0] sp, input logic hd, input logic [7:0] dp,
      input logic [3:0] cnt, input logic ovf);
      vec_t v;
      v.rst = rst; v.wv = wv; v.wp = wp; v.c0 = c0; v.c0p = c0p;
      v.c1 = c1; v.c1p = c1p; v.fin = fin;
      v.rdy = rdy; v.a0 = a0; v.a1 = a1; v.en = en; v.hs = hs; v.sp = sp;
      v.hd = hd; v.dp = dp; v.cnt = cnt; v.ovf = ovf;
      return v;
   endfunction

   // Packs the observed outputs in a fixed order: rdy a0 a1 en hs sp hd dp cnt ovf
   function automatic logic [26:0] pack_obs();
      return {wakeReady, core0DescheduleAck, core1DescheduleAck, schedEnabled,
              hasSchedule, schedulePid, hasDeschedule, deschedulePid, queueCount, overflowError};
   endfunction

   function automatic logic [26:0] pack_exp(input vec_t v);
      return {v.rdy, v.a0, v.a1, v.en, v.hs, v.sp, v.hd, v.dp, v.cnt, v.ovf};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1; wakeValid = 1'b0; wakePid = 8'd0;
      core0DescheduleReq = 1'b0; core0DeschedulePid = 8'd0;
      core1DescheduleReq = 1'b0; core1DeschedulePid = 8'd0;
      schedFinished = 1'b0;
      step();

      //            rst  wv   wp    c0   c0p   c1   c1p   fin | rdy  a0   a1   en   hs   sp    hd   dp    cnt   ovf
      // reset state
      vecs.push_back(mk(1'b1,1'b0,8'd0, 1'b0,8'd0, 1'b0,8'd0, 1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,8'd0, 4'd0,1'b0));
      // single wake-up pid 1
      vecs.push_back(mk(1'b0,1'b1,8'd1, 1'b0,8'd0, 1'b0,8'd0, 1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,8'd0, 4'd1,1'b0));
      vecs.push_back(mk(1'b0,1'b0,8'd0, 1'b0,8'd0, 1'b0,8'd0, 1'b0, 1'b1,1'b0,1'b0,1'b1,1'b1,8'd1, 1'b0,8'd0, 4'd1,1'b0));
      vecs.push_back(mk(1'b0,1'b0,8'd0, 1'b0,8'd0, 1'b0,8'd0, 1'b0, 1'b1,1'b0,1'b0,1'b1,1'b1,8'd1, 1'b0,8'd0, 4'd1,1'b0));
      vecs.push_back(mk(1'b0,1'b0,8'd0, 1'b0,8'd0, 1'b0,8'd0, 1'b1, 1'b1,1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,8'd0, 4'd0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,8'd0, 1'b0,8'd0, 1'b0,8'd0, 1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,8'd0, 4'd0,1'b0));
      // pids 2 and 3 back-to-back; second issue waits for finished to fall
      vecs.push_back(mk(1'b0,1'b1,8'd2, 1'b0,8'd0, 1'b0,8'd0, 1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,8'd0, 4'd1,1'b0));
      vecs.push_back(mk(1'b0,1'b1,8'd3, 1'b0,8'd0, 1'b0,8'd0, 1'b0, 1'b1,1'b0,1'b0,1'b1,1'b1,8'd2, 1'b0,8'd0, 4'd2,1'b0));
      vecs.push_back(mk(1'b0,1'b0,8'd0, 1'b0,8'd0, 1'b0,8'd0, 1'b1, 1'b1,1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,8'd0, 4'd1,1'b0));
      vecs.push_back(mk(1'b0,1'b0,8'd0, 1'b0,8'd0, 1'b0,8'd0, 1'b1, 1'b1,1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,8'd0, 4'd1,1'b0));
      vecs.push_back(mk(1'b0,1'b0,8'd0, 1'b0,8'd0, 1'b0,8'd0, 1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,8'd0, 4'd1,1'b0));
      vecs.push_back(mk(1'b0,1'b0,8'd0, 1'b0,8'd0, 1'b0,8'd0, 1'b0, 1'b1,1'b0,1'b0,1'b1,1'b1,8'd3, 1'b0,8'd0, 4'd1,1'b0));
      vecs.push_back(mk(1'b0,1'b0,8'd0, 1'b0,8'd0, 1'b0,8'd0, 1'b1, 1'b1,1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,8'd0, 4'd0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,8'd0, 1'b0,8'd0, 1'b0,8'd0, 1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,8'd0, 4'd0,1'b0));
      // core 0 deschedule pid 1 alone; ack pulses once
      vecs.push_back(mk(1'b0,1'b0,8'd0, 1'b1,8'd1, 1'b0,8'd0, 1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,8'd0, 1'b1,8'd1, 4'd0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,8'd0, 1'b1,8'd1, 1'b0,8'd0, 1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,8'd0, 1'b1,8'd1, 4'd0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,8'd0, 1'b1,8'd1, 1'b0,8'd0, 1'b1, 1'b1,1'b1,1'b0,1'b0,1'b0,8'd0, 1'b0,8'd0, 4'd0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,8'd0, 1'b0,8'd0, 1'b0,8'd0, 1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,8'd0, 4'd0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,8'd0, 1'b0,8'd0, 1'b0,8'd0, 1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,8'd0, 4'd0,1'b0));
      // queue pid 4, then both cores request: merge core0 pid 2 with pid 4, then core1 pid 3 alone
      vecs.push_back(mk(1'b0,1'b1,8'd4, 1'b0,8'd0, 1'b0,8'd0, 1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,8'd0, 4'd1,1'b0));
      vecs.push_back(mk(1'b0,1'b0,8'd0, 1'b1,8'd2, 1'b1,8'd3, 1'b0, 1'b1,1'b0,1'b0,1'b1,1'b1,8'd4, 1'b1,8'd2, 4'd1,1'b0));
      vecs.push_back(mk(1'b0,1'b0,8'd0, 1'b1,8'd2, 1'b1,8'd3, 1'b1, 1'b1,1'b1,1'b0,1'b0,1'b0,8'd0, 1'b0,8'd0, 4'd0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,8'd0, 1'b0,8'd0, 1'b1,8'd3, 1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,8'd0, 4'd0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,8'd0, 1'b0,8'd0, 1'b1,8'd3, 1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,8'd0, 1'b1,8'd3, 4'd0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,8'd0, 1'b0,8'd0, 1'b1,8'd3, 1'b1, 1'b1,1'b0,1'b1,1'b0,1'b0,8'd0, 1'b0,8'd0, 4'd0,1'b0));
      vecs.push_back(mk(1'b0,1'b0,8'd0, 1'b0,8'd0, 1'b0,8'd0, 1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,8'd0, 4'd0,1'b0));

      for (int i = 0; i < vecs.size(); i++) begin
         reset              = vecs[i].rst;
         wakeValid          = vecs[i].wv;
         wakePid            = vecs[i].wp;
         core0DescheduleReq = vecs[i].c0;
         core0DeschedulePid = vecs[i].c0p;
         core1DescheduleReq = vecs[i].c1;
         core1DeschedulePid = vecs[i].c1p;
         schedFinished      = vecs[i].fin;
         step();
         chk($sformatf("vec%0d", i), {5'd0, pack_obs()}, {5'd0, pack_exp(vecs[i])});
      end

      // FIFO fill: 9 pushes with finished held low, ninth overflows
      wakeValid = 1'b0; schedFinished = 1'b0;
      core0DescheduleReq = 1'b0; core1DescheduleReq = 1'b0;
      for (int k = 0; k < 9; k++) begin
         wakeValid = 1'b1;
         wakePid   = 8'd10 + 8'(k);
         step();
         if (k == 6) begin
            chk("fill7_ready", {31'd0, wakeReady}, 32'd1);
            chk("fill7_count", {28'd0, queueCount}, 32'd7);
         end
         if (k == 7) begin
            chk("full_ready", {31'd0, wakeReady}, 32'd0);
            chk("full_count", {28'd0, queueCount}, 32'd8);
            chk("full_ovf", {31'd0, overflowError}, 32'd0);
         end
      end
      wakeValid = 1'b0;
      chk("ovf_set", {31'd0, overflowError}, 32'd1);
      chk("ovf_count", {28'd0, queueCount}, 32'd8);
      chk("ovf_ready", {31'd0, wakeReady}, 32'd0);

      // Drain the eight queued pids in order, one transaction each
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("drain%0d_en", k), {31'd0, schedEnabled}, 32'd1);
         chk($sformatf("drain%0d_pid", k), {24'd0, schedulePid}, 32'd10 + 32'(k));
         schedFinished = 1'b1;
         step();
         chk($sformatf("drain%0d_cnt", k), {28'd0, queueCount}, 32'd7 - 32'(k));
         schedFinished = 1'b0;
         step();
         step();
      end
      chk("drain_idle_en", {31'd0, schedEnabled}, 32'd0);
      chk("drain_ovf_sticky", {31'd0, overflowError}, 32'd1);

      // Reset during a merged ISSUE: no ack, queue emptied, overflow cleared
      wakeValid = 1'b1; wakePid = 8'd5;
      step();
      wakeValid = 1'b0;
      core0DescheduleReq = 1'b1; core0DeschedulePid = 8'd7;
      step();
      chk("pre_rst_en", {31'd0, schedEnabled}, 32'd1);
      chk("pre_rst_dpid", {24'd0, deschedulePid}, 32'd7);
      reset = 1'b1; schedFinished = 1'b1;
      step();
      chk("rst_en", {31'd0, schedEnabled}, 32'd0);
      chk("rst_count", {28'd0, queueCount}, 32'd0);
      chk("rst_ack0", {31'd0, core0DescheduleAck}, 32'd0);
      chk("rst_ovf", {31'd0, overflowError}, 32'd0);
      chk("rst_ready", {31'd0, wakeReady}, 32'd1);
      reset = 1'b0; schedFinished = 1'b0; core0DescheduleReq = 1'b0;
      step();
      chk("post_rst_ack0", {31'd0, core0DescheduleAck}, 32'd0);
      chk("post_rst_en", {31'd0, schedEnabled}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
